fetch: RTL and testbench

Instruction-fetch stage directly upstream of decode and immediate generation. It owns the PC register, issues reads to a synchronous instruction memory with fixed 1-cycle latency, and buffers returned instructions in a 2-entry queue. The queue presents {pc, insn} to decode over a valid/ready handshake. A redirect from execute (branch or jump) flushes all buffered and in-flight fetches and restarts at the target.

---
 rtl/fetch.sv | 92 +++++++++
 tb/tb_fetch.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch.sv
// Instruction-fetch stage: owns the PC, issues reads to a 1-cycle synchronous imem, and
// buffers responses in a 2-entry queue presented to decode over valid/ready.
module fetch #(
    parameter int unsigned      DWIDTH   = 32,
    parameter int unsigned      AWIDTH   = 32,
    parameter logic [AWIDTH-1:0] BASEADDR = 32'h0100_0000,
    parameter logic [DWIDTH-1:0] NOP      = 32'h0000_0013
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_read_o,
    output logic [AWIDTH-1:0] imem_addr_o,
    input  logic [DWIDTH-1:0] imem_data_i,
    output logic              insn_valid_o,
    output logic [DWIDTH-1:0] insn_o,
    output logic [AWIDTH-1:0] pc_o,
    input  logic              insn_ready_i,
    input  logic              redirect_i,
    input  logic [AWIDTH-1:0] redirect_pc_i
);

    logic [AWIDTH-1:0] pc_q;
    logic              inflight_q;
    logic [AWIDTH-1:0] inflight_pc_q;

    logic [AWIDTH-1:0] q_pc   [2];
    logic [DWIDTH-1:0] q_insn [2];
    logic              rd_ptr_q;
    logic              wr_ptr_q;
    logic [1:0]        count_q;

    logic       deq;
    logic       enq;
    logic       issue;
    logic [2:0] occ;

    assign deq = insn_valid_o & insn_ready_i;
    assign enq = inflight_q & ~redirect_i;

    // Credit check: entries held plus the one in flight, minus the one leaving, must leave room.
    assign occ   = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, deq};
    assign issue = ~reset & ~redirect_i & (occ < 3'd2);

    assign imem_read_o = issue;
    assign imem_addr_o = pc_q;

    always_comb begin
        insn_valid_o = (count_q != 2'd0);
        insn_o       = NOP;
        pc_o         = '0;
        if (insn_valid_o) begin
            insn_o = q_insn[rd_ptr_q];
            pc_o   = q_pc[rd_ptr_q];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q          <= BASEADDR;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            rd_ptr_q      <= 1'b0;
            wr_ptr_q      <= 1'b0;
            count_q       <= 2'd0;
        end else if (redirect_i) begin
            // Flush queue and drop the response arriving this cycle.
            pc_q       <= {redirect_pc_i[AWIDTH-1:2], 2'b00};
            inflight_q <= 1'b0;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
        end else begin
            inflight_q <= issue;
            if (issue) begin
                pc_q          <= pc_q + AWIDTH'(4);
                inflight_pc_q <= pc_q;
            end
            if (enq) wr_ptr_q <= ~wr_ptr_q;
            if (deq) rd_ptr_q <= ~rd_ptr_q;
            count_q <= count_q + {1'b0, enq} - {1'b0, deq};
        end
    end

    // Queue storage needs no reset; count gates visibility.
    always_ff @(posedge clk) begin
        if (!reset && enq) begin
            q_pc[wr_ptr_q]   <= inflight_pc_q;
            q_insn[wr_ptr_q] <= imem_data_i;
        end
    end

endmodule

// File: tb/tb_fetch.sv
// Directed self-checking bench for fetch; memory returns address ^ 0x5A000000 as data
// so pc and instruction fields are distinguishable.
module tb_fetch;

    localparam logic [31:0] Base = 32'h0100_0000;
    localparam logic [31:0] Nop  = 32'h0000_0013;
    localparam logic [31:0] Key  = 32'h5A00_0000;

    logic        clk;
    logic        reset;
    logic        imem_read;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        insn_valid;
    logic [31:0] insn;
    logic [31:0] pc;
    logic        insn_ready;
    logic        redirect;
    logic [31:0] redirect_pc;

    int n_checks;
    int n_pass;

    fetch dut (
        .clk          (clk),
        .reset        (reset),
        .imem_read_o  (imem_read),
        .imem_addr_o  (imem_addr),
        .imem_data_i  (imem_data),
        .insn_valid_o (insn_valid),
        .insn_o       (insn),
        .pc_o         (pc),
        .insn_ready_i (insn_ready),
        .redirect_i   (redirect),
        .redirect_pc_i(redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) imem_data <= imem_read ? (imem_addr ^ Key) : 32'hDEAD_BEEF;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [31:0] p);
        check_eq({tag, ".valid"}, {31'b0, insn_valid}, {31'b0, v});
        check_eq({tag, ".pc"}, pc, v ? p : 32'h0);
        check_eq({tag, ".insn"}, insn, v ? (p ^ Key) : Nop);
    endtask

    task automatic chk_rd(input string tag, input logic r, input logic [31:0] a);
        check_eq({tag, ".read"}, {31'b0, imem_read}, {31'b0, r});
        if (r) check_eq({tag, ".addr"}, imem_addr, a);
    endtask

    // One reset cycle; leaves us at cycle 0 after release with the given ready.
    task automatic do_reset(input logic rdy);
        reset = 1'b1;
        redirect = 1'b0;
        insn_ready = rdy;
        #0;
        chk_rd("rst_comb", 1'b0, 32'h0);
        tick();
        chk_out("rst", 1'b0, 32'h0);
        reset = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_pass = 0;
        reset = 1'b1;
        redirect = 1'b0;
        redirect_pc = 32'h0;
        insn_ready = 1'b0;
        tick();

        // Streaming at full rate
        do_reset(1'b1);
        #1;
        chk_rd("s0", 1'b1, Base);
        tick();
        chk_rd("s1", 1'b1, Base + 4);
        chk_out("s1", 1'b0, 32'h0);
        tick();
        for (int i = 2; i < 8; i++) begin
            chk_rd("s", 1'b1, Base + 32'(4 * i));
            chk_out("s", 1'b1, Base + 32'(4 * (i - 2)));
            tick();
        end

        // Backpressure from first valid
        do_reset(1'b0);
        tick();
        tick();
        for (int i = 0; i < 6; i++) begin
            chk_out("bp", 1'b1, Base);
            chk_rd("bp", 1'b0, 32'h0);
            tick();
        end
        insn_ready = 1'b1;
        #1;
        chk_out("bp_rel0", 1'b1, Base);
        chk_rd("bp_rel0", 1'b1, Base + 8);
        tick();
        chk_out("bp_rel1", 1'b1, Base + 4);
        tick();
        chk_out("bp_rel2", 1'b1, Base + 8);
        tick();
        chk_out("bp_rel3", 1'b1, Base + 12);

        // Redirect with one entry queued and one in flight
        do_reset(1'b0);
        tick();
        tick();
        redirect = 1'b1;
        redirect_pc = 32'h0100_0103;
        #1;
        chk_rd("rd_r", 1'b0, 32'h0);
        tick();
        redirect = 1'b0;
        insn_ready = 1'b1;
        #1;
        chk_out("rd_r1", 1'b0, 32'h0);
        chk_rd("rd_r1", 1'b1, 32'h0100_0100);
        tick();
        chk_out("rd_r2", 1'b0, 32'h0);
        tick();
        chk_out("rd_r3", 1'b1, 32'h0100_0100);
        tick();
        chk_out("rd_r4", 1'b1, 32'h0100_0104);

        // Redirect coinciding with dequeue and response, then a second redirect
        do_reset(1'b1);
        tick();
        tick();
        chk_out("dr_pre", 1'b1, Base);
        redirect = 1'b1;
        redirect_pc = 32'h0000_0200;
        tick();
        redirect_pc = 32'h0000_0300;
        #1;
        chk_out("dr_r1", 1'b0, 32'h0);
        chk_rd("dr_r1", 1'b0, 32'h0);
        tick();
        redirect = 1'b0;
        #1;
        chk_out("dr_r2", 1'b0, 32'h0);
        chk_rd("dr_r2", 1'b1, 32'h0000_0300);
        tick();
        chk_out("dr_r3", 1'b0, 32'h0);
        tick();
        chk_out("dr_r4", 1'b1, 32'h0000_0300);
        tick();
        chk_out("dr_r5", 1'b1, 32'h0000_0304);

        // PC wrap
        redirect = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect = 1'b0;
        #1;
        chk_rd("wr1", 1'b1, 32'hFFFF_FFFC);
        tick();
        chk_rd("wr2", 1'b1, 32'h0000_0000);
        tick();
        chk_out("wr3", 1'b1, 32'hFFFF_FFFC);
        tick();
        chk_out("wr4", 1'b1, 32'h0000_0000);

        // Reset mid-operation with queued and in-flight work
        do_reset(1'b0);
        tick();
        tick();
        chk_out("mr_pre", 1'b1, Base);
        reset = 1'b1;
        #1;
        chk_rd("mr_r", 1'b0, 32'h0);
        tick();
        reset = 1'b0;
        insn_ready = 1'b1;
        #1;
        chk_out("mr1", 1'b0, 32'h0);
        chk_rd("mr1", 1'b1, Base);
        tick();
        chk_out("mr2", 1'b0, 32'h0);
        tick();
        chk_out("mr3", 1'b1, Base);
        tick();
        chk_out("mr4", 1'b1, Base + 4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
